// File: rtl/audio_recorder.sv
// Codec capture engine: pops input FIFO samples, keeps 1 of DECIM, writes song RAM.
// Define AUDIO_RECORDER_MIX_EN to store the floor-average of left and right.
module audio_recorder #(
    parameter int ADDR_W = 8,
    parameter int DECIM  = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    input  logic [31:0]       right_channel_audio_in,
    output logic              read_audio_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic              r_stop;
    logic [31:0]       r_sample;
    logic [31:0]       w_word;
    logic              w_keep;
    logic              w_full;
    logic              w_stop;

`ifdef AUDIO_RECORDER_MIX_EN
    logic [32:0] w_sum;
    assign w_sum  = {left_channel_audio_in[31], left_channel_audio_in}
                  + {right_channel_audio_in[31], right_channel_audio_in};
    assign w_word = w_sum[32:1];
`else
    logic w_unused_right;
    assign w_unused_right = ^right_channel_audio_in;
    assign w_word         = left_channel_audio_in;
`endif

    assign w_keep = (r_cnt == CNT_W'(DECIM - 1));
    assign w_full = (r_addr == {ADDR_W{1'b1}});
    assign w_stop = stop | r_stop;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_stop) w_next = S_DONE;
                else if (audio_in_available) w_next = S_CAPT;
            end
            S_CAPT: begin
                w_next = w_keep ? S_WRITE : S_WAIT;
            end
            S_WRITE: begin
                w_next = (w_full || w_stop) ? S_DONE : S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Stop seen mid-sample is held so the sample in flight can finish first.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_words  <= '0;
            r_stop   <= 1'b0;
            r_sample <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_words <= '0;
                        r_stop  <= 1'b0;
                    end
                end
                S_CAPT: begin
                    r_sample <= w_word;
                    r_cnt    <= w_keep ? '0 : r_cnt + CNT_W'(1);
                    if (stop) r_stop <= 1'b1;
                end
                S_WRITE: begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_words <= r_words + (ADDR_W + 1)'(1);
                    if (stop) r_stop <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign read_audio_in = (r_state == S_CAPT);
    assign mem_wren      = (r_state == S_WRITE);
    assign mem_address   = r_addr;
    assign mem_data      = r_sample;
    assign words_written = r_words;
    assign busy          = (r_state == S_WAIT) || (r_state == S_CAPT)
                        || (r_state == S_WRITE);
    assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_audio_recorder.sv
// Directed bench for audio_recorder: FIFO model, write scoreboard, stop/reset cases.
module tb_audio_recorder;

    localparam int ADDR_W = 8;
    localparam int DECIM  = 4;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } smp_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              avail = 1'b0;
    logic [31:0]       left_in = '0;
    logic [31:0]       right_in = '0;
    logic              read_audio_in;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;

    logic gate = 1'b1;
    logic pend = 1'b0;
    logic prev_rd = 1'b0;
    int   pops = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rec_cnt = 0;
    int   exp_addr = 0;
    int   p0;
    int   n;

    smp_t fifo[$];
    wr_t  exp_q[$];

    audio_recorder #(.ADDR_W(ADDR_W), .DECIM(DECIM)) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .start                  (start),
        .stop                   (stop),
        .audio_in_available     (avail),
        .left_channel_audio_in  (left_in),
        .right_channel_audio_in (right_in),
        .read_audio_in          (read_audio_in),
        .mem_address            (mem_address),
        .mem_data               (mem_data),
        .mem_wren               (mem_wren),
        .busy                   (busy),
        .done                   (done),
        .words_written          (words_written)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [31:0] l, logic [31:0] r);
`ifdef AUDIO_RECORDER_MIX_EN
        longint s;
        s = (longint'($signed(l)) + longint'($signed(r))) >>> 1;
        return s[31:0];
`else
        logic [31:0] unused_r;
        unused_r = r;
        return l;
`endif
    endfunction

    // FIFO head stays put through the pop cycle; it advances one cycle later.
    always @(negedge CLOCK_50) begin
        if (mem_wren) begin
            check("wr_after_pop", 64'(prev_rd), 64'd1);
            check("wr_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_address), 64'(e.a));
                check("wr_data", 64'(mem_data), 64'(e.d));
            end
        end
        if (pend && fifo.size() != 0) void'(fifo.pop_front());
        pend = read_audio_in;
        if (read_audio_in) begin
            pops++;
            check("pop_width", 64'(prev_rd), 64'd0);
        end
        prev_rd  = read_audio_in;
        avail    = gate && (fifo.size() != 0);
        left_in  = (fifo.size() != 0) ? fifo[0].l : 32'h0;
        right_in = (fifo.size() != 0) ? fifo[0].r : 32'h0;
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic push_s(logic [31:0] l, logic [31:0] r, bit track);
        smp_t s;
        wr_t  w;
        s.l = l;
        s.r = r;
        fifo.push_back(s);
        rec_cnt++;
        if (track && (rec_cnt % DECIM) == 0) begin
            w.a = ADDR_W'(exp_addr);
            w.d = model(l, r);
            exp_q.push_back(w);
            exp_addr++;
        end
    endtask

    task automatic push_exp(logic [31:0] d);
        wr_t w;
        w.a = ADDR_W'(exp_addr);
        w.d = d;
        exp_q.push_back(w);
        exp_addr++;
    endtask

    task automatic begin_rec();
        rec_cnt  = 0;
        exp_addr = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rec_busy", 64'(busy), 64'd1);
        check("rec_done_clr", 64'(done), 64'd0);
        check("rec_words_clr", 64'(words_written), 64'd0);
    endtask

    task automatic end_rec(int words);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("end_done", 64'(done), 64'd1);
        check("end_words", 64'(words_written), 64'(words));
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_pops(int target, int budget);
        int k;
        k = 0;
        while (pops < target && k < budget) begin
            tick();
            k++;
        end
        check("pop_count", 64'(pops), 64'(target));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        gate  = 1'b1;
        for (int i = 0; i < 3; i++) push_s(32'h55 + i, 32'h0, 1'b0);
        repeat (2) tick();
        check("rst_read", 64'(read_audio_in), 64'd0);
        check("rst_wren", 64'(mem_wren), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_data", 64'(mem_data), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("idle_nopop", 64'(pops), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        fifo.delete();
        tick();

        // Decimate by 4: 12 samples, 3 writes of 4, 8, 12.
        p0 = pops;
        begin_rec();
        for (int k = 1; k <= 12; k++) push_s(32'(k), ~32'(k), 1'b1);
        wait_pops(p0 + 12, 200);
        repeat (3) tick();
        check("dec_words", 64'(words_written), 64'd3);
        end_rec(3);

        // Stop in WAIT after 5 words; later samples must stay unpopped.
        p0 = pops;
        begin_rec();
        for (int k = 0; k < 20; k++) push_s(32'h200 + 32'(k), 32'h0, 1'b1);
        wait_pops(p0 + 20, 300);
        repeat (3) tick();
        check("sw_words_pre", 64'(words_written), 64'd5);
        gate = 1'b0;
        for (int k = 0; k < 4; k++) push_s(32'h300 + 32'(k), 32'h0, 1'b0);
        end_rec(5);
        gate = 1'b1;
        repeat (10) tick();
        check("sw_nopop", 64'(pops), 64'(p0 + 20));
        fifo.delete();
        tick();

        // Stop during a non-kept capture: latched, ends at next WAIT.
        p0 = pops;
        begin_rec();
        for (int k = 0; k < 4; k++) push_s(32'h400 + 32'(k), 32'h0, 1'b0);
        n = 0;
        while (!read_audio_in && n < 20) begin tick(); n++; end
        check("sc_saw_pop", 64'(read_audio_in), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("sc_done", 64'(done), 64'd1);
        check("sc_words", 64'(words_written), 64'd0);
        repeat (5) tick();
        check("sc_pops", 64'(pops), 64'(p0 + 1));
        fifo.delete();
        tick();

        // Stop during WRITE: that write lands, then DONE.
        p0 = pops;
        begin_rec();
        for (int k = 0; k < 4; k++) push_s(32'h500 + 32'(k), 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) push_s(32'h600 + 32'(k), 32'h0, 1'b0);
        n = 0;
        while (!mem_wren && n < 40) begin tick(); n++; end
        check("swr_saw_wr", 64'(mem_wren), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("swr_done", 64'(done), 64'd1);
        check("swr_words", 64'(words_written), 64'd1);
        repeat (5) tick();
        check("swr_pops", 64'(pops), 64'(p0 + 4));
        fifo.delete();
        tick();

        // Start and stop together: start wins, stop then ends with 0 words.
        p0 = pops;
        for (int k = 0; k < 3; k++) push_s(32'h700, 32'h0, 1'b0);
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        check("ss_wait", 64'(busy), 64'd1);
        tick();
        stop = 1'b0;
        check("ss_done", 64'(done), 64'd1);
        check("ss_words", 64'(words_written), 64'd0);
        check("ss_nopop", 64'(pops), 64'(p0));
        fifo.delete();
        tick();

        // Gapped FIFO: one sample per 7-cycle availability window.
        p0 = pops;
        begin_rec();
        for (int w = 0; w < 8; w++) begin
            gate = 1'b1;
            push_s(32'h800 + 32'(w), 32'h0, 1'b1);
            repeat (7) tick();
            gate = 1'b0;
            repeat (7) tick();
            check("gap_pop", 64'(pops), 64'(p0 + w + 1));
        end
        gate = 1'b1;
        end_rec(2);

        // Stored word format, with and without channel mixing.
        begin_rec();
        push_s(32'h1, 32'h2, 1'b0);
        push_s(32'h3, 32'h4, 1'b0);
        push_s(32'h5, 32'h6, 1'b0);
        push_s(32'd5, 32'd9, 1'b0);
`ifdef AUDIO_RECORDER_MIX_EN
        push_exp(32'h00000007);
`else
        push_exp(32'h00000005);
`endif
        for (int k = 0; k < 3; k++) push_s(32'h11, 32'h22, 1'b0);
        push_s(32'hFFFFFFFD, 32'h0, 1'b0);
`ifdef AUDIO_RECORDER_MIX_EN
        push_exp(32'hFFFFFFFE);
`else
        push_exp(32'hFFFFFFFD);
`endif
        for (int k = 0; k < 3; k++) push_s(32'h33, 32'h44, 1'b0);
        push_s(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        push_exp(32'h7FFFFFFF);
        for (int k = 0; k < 4; k++) push_s(32'h80000000, 32'h80000000, 1'b1);
        p0 = pops;
        wait_pops(p0 + 16, 300);
        repeat (3) tick();
        end_rec(4);

        // Fill all 256 words; the 257th kept sample is never popped.
        p0 = pops;
        begin_rec();
        for (int k = 0; k < 256 * DECIM; k++) push_s(32'h10 + 32'(k), 32'h0, 1'b1);
        for (int k = 0; k < DECIM; k++) push_s(32'hDEAD, 32'h0, 1'b0);
        n = 0;
        while (!done && n < 4000) begin tick(); n++; end
        check("full_done", 64'(done), 64'd1);
        check("full_words", 64'(words_written), 64'd256);
        check("full_addr_wrap", 64'(mem_address), 64'd0);
        repeat (20) tick();
        check("full_pops", 64'(pops), 64'(p0 + 256 * DECIM));
        check("full_sb", 64'(exp_q.size()), 64'd0);
        fifo.delete();
        tick();

        // Reset during the kept capture: no write may follow.
        p0 = pops;
        begin_rec();
        for (int k = 0; k < 4; k++) push_s(32'h900 + 32'(k), 32'h0, 1'b0);
        n = 0;
        while (!(read_audio_in && pops == p0 + 4) && n < 40) begin tick(); n++; end
        check("mr_saw_pop", 64'(pops), 64'(p0 + 4));
        reset = 1'b1;
        tick();
        check("mr_wren", 64'(mem_wren), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_words", 64'(words_written), 64'd0);
        check("mr_data", 64'(mem_data), 64'd0);
        reset = 1'b0;
        fifo.delete();
        repeat (5) tick();
        check("mr_idle", 64'(busy | done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
